// File: rtl/rom_stream_pkg.sv
// Shared types and sizing helpers for the ROM stream reader.
// Imported by the FIFO and the top-level sequencer.
package rom_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int ADDR_W_DEF     = 3;
  localparam int DATA_W_DEF     = 4;
  localparam int RD_LAT_DEF     = 1;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int cnt_width(
    input int depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rom_stream_reader_fifo.sv
// Registered-storage FIFO with first-word-visible output.
// Holds ROM words plus their last flag.
module sync_fifo
  import rom_stream_pkg::*;
#(
  parameter int W     = DATA_W_DEF + 1,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1))
                ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1))
                ? '0 : rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer for the synchronous lookup ROM.
// Credit-limited issue keeps every returned word in the output FIFO.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int UW = CW + 1;
  localparam int LW = ADDR_W + 1;
  localparam logic [UW-1:0] DEPTH_U = UW'(FIFO_DEPTH);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] next_addr;
  logic [LW-1:0]     remaining;
  logic [CW-1:0]     inflight;
  logic [RD_LAT:0]   pv;
  logic [RD_LAT:0]   pl;

  logic [ADDR_W-1:0] iss_addr;
  logic [LW-1:0]     rem_src;
  logic              iss_last;
  logic              issue;
  logic              accept;
  logic              push;
  logic              pop;
  logic [UW-1:0]     used;
  logic [DATA_W:0]   fifo_din;
  logic [DATA_W:0]   fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  assign cmd_ready = rst_n & (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready
                   & (cmd_len != '0);

  // Pops in flight this cycle are not credited back.
  assign used = UW'(inflight) + UW'(fifo_count);

  always_comb begin
    iss_addr = next_addr;
    rem_src  = remaining;
    issue    = 1'b0;
    if (state == IDLE) begin
      iss_addr = cmd_base;
      rem_src  = cmd_len;
      issue    = accept;
    end else if (state == READ) begin
      issue = (remaining != '0) & ~fifo_full
            & (used < DEPTH_U);
    end
    iss_last = (rem_src == LW'(1));
  end

  assign push     = pv[RD_LAT];
  assign fifo_din = {pl[RD_LAT], rom_data};
  assign pop      = out_valid & out_ready;

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_dout[DATA_W-1:0];
  assign out_last  = fifo_dout[DATA_W] & ~fifo_empty;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nx = iss_last ? DRAIN : READ;
        end
      end
      READ: begin
        if (issue && iss_last) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_dout[DATA_W]) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rom_addr  <= '0;
      next_addr <= '0;
      remaining <= '0;
      inflight  <= '0;
      pv        <= '0;
      pl        <= '0;
    end else begin
      state <= state_nx;
      pv    <= {pv[RD_LAT-1:0], issue};
      pl    <= {pl[RD_LAT-1:0], issue & iss_last};
      if (issue) begin
        rom_addr  <= iss_addr;
        next_addr <= iss_addr + ADDR_W'(1);
        remaining <= rem_src - LW'(1);
      end
      case ({issue, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  sync_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Upstream sequencer for the synchronous lookup ROM. It accepts a burst command (base address and length) and drives the ROM address port.
- Captures the returned words and streams them downstream on a valid/ready interface, tagging the final word with last.
- Absorbs ROM read latency and downstream backpressure with a credit-limited output FIFO, so no word is ever dropped.

Parameters:
- ADDR_W, 3, ROM address width; ROM depth is 2^ADDR_W.
- DATA_W, 4, ROM word width.
- RD_LAT, 1, ROM read latency in cycles: address stable in cycle t gives valid rom_data in cycle t+RD_LAT. Legal range 1..4.
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ RD_LAT+1. Full throughput requires ≥ RD_LAT+3.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_base  in  ADDR_W  first ROM address of the burst
- cmd_len  in  ADDR_W+1  number of words, 0..2^ADDR_W
- rom_addr  out  ADDR_W  registered address to the ROM
- rom_data  in  DATA_W  ROM read data
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the word
- out_data  out  DATA_W  streamed word
- out_last  out  1  qualifies the final word of the burst
- busy  out  1  high from command accept until the last word is popped

Behaviour:
- Reset values: cmd_ready=0 while rst_n is low and 1 in the first cycle after release. rom_addr=0, out_valid=0, out_data=0, out_last=0, busy=0. FIFO, inflight pipe and counters all cleared.
- Reset mid-burst: all state is discarded immediately. No residual words appear after release.
- FSM states:
  - IDLE: cmd_valid&cmd_ready → READ, capturing base and len. If len=0 it stays in IDLE, busy never rises and no output is produced.
  - READ: issues addresses. Goes to DRAIN on the edge where the last address is issued.
  - DRAIN: waits until inflight=0, the FIFO is empty and the last word has been popped, then goes to IDLE.
- Issue rule, evaluated in READ each cycle:
  - Issue when remaining>0 and (inflight + fifo_count) < FIFO_DEPTH.
  - The current-cycle pop is not credited back; the check is deliberately conservative.
- On issue: rom_addr<=next_addr, next_addr<=next_addr+1 mod 2^ADDR_W (wrap-around), remaining--, inflight++.
- rom_addr holds its last issued value when not issuing.
- Capture:
  - An RD_LAT-deep valid/last shift pipe tracks each issue.
  - rom_data is written into the FIFO at the end of cycle issue+1+RD_LAT, with last=1 for the final address. inflight decrements on the same edge.
- Credits guarantee the FIFO never overflows.
- Latency: command accepted at the end of cycle 0 → rom_addr valid in cycle 1 → (RD_LAT=1) data captured at the end of cycle 2 → out_valid in cycle 3.
- Output side:
  - out_valid = FIFO not empty; out_data and out_last come from the FIFO head.
  - Pop on out_valid&out_ready.
  - out_data/out_last stay stable while out_valid&!out_ready.
- Simultaneous FIFO push and pop in the same cycle is legal, and count is unchanged.
- Throughput: with out_ready held high and FIFO_DEPTH ≥ RD_LAT+3, one word per cycle with no bubbles after the first word.
- cmd_len=2^ADDR_W reads the whole ROM once, starting at base and wrapping.
- cmd_valid while busy is ignored: cmd_ready=0 and the command is not captured.

Decomposition:
- Package rom_stream_pkg:
  - state enum {IDLE, READ, DRAIN}, 2 bits.
  - Default width constants.
  - A function computing $clog2(FIFO_DEPTH+1) for the count width.
- Sub-module sync_fifo: parameterised width DATA_W+1 (data plus last bit) and depth FIFO_DEPTH. Ports push, pop, din, dout, count, empty, full. Registered storage, first-word-visible dout, asynchronous reset.

Test Plan:
- Bench ROM model returns data = (2·addr) mod 16 with RD_LAT=1, out_ready=1.
- Tests:
  1. Basic burst: base=2, len=3 → rom_addr 2,3,4 in cycles 1-3. out_data 4,6,8 in cycles 3,4,5, last only on 8. busy falls after cycle 5.
  2. Wrap-around: base=6, len=4 → rom_addr 6,7,0,1, out_data 12,14,0,2, with last on 2.
  3. Backpressure: base=0, len=8, out_ready=0 for 10 cycles after the first out_valid.
     - Issues stop at FIFO_DEPTH pending (rom_addr holds 3).
     - out_data holds 0 throughout the stall.
     - On release, words 0,2,…,14 arrive in order with none lost or duplicated.
  4. Zero-length command: cmd_len=0 → cmd_ready stays 1, busy stays 0, no out_valid.
     - A following base=5, len=1 is accepted next cycle → single word 10 with last=1.
  5. Reset mid-burst: assert rst_n=0 in cycle 4 of a len=8 burst.
     - All outputs go to reset values at once.
     - After release, a base=1, len=2 burst yields exactly 2,4.
  6. Busy command rejection: cmd_valid held with base=3 during an active burst.
     - Not accepted until the burst's last pop, then accepted in IDLE.
